// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder controller. A single one-bit full adder is stepped over
// WIDTH-bit operands, one bit per clock, LSB first. The block owns the operand
// shift registers, the carry flip-flop, the bit counter and the
// start/busy/done handshake.
//
// Ports:
//   clk    in   1      system clock, rising-edge active
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      add request, sampled only in IDLE
//   a      in   WIDTH  operand A, sampled on the accepting edge
//   b      in   WIDTH  operand B, sampled on the accepting edge
//   cin    in   1      carry-in, sampled on the accepting edge
//   busy   out  1      high while RUN or DONE
//   done   out  1      one-cycle pulse, result valid
//   sum    out  WIDTH  registered result
//   cout   out  1      registered final carry
//
// Timing (E0 = accepting edge): RUN covers edges E1..E(WIDTH); sum/cout and
// done are valid from E(WIDTH) to E(WIDTH+1); IDLE again after E(WIDTH+1).
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter only has to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One-bit full adder: returns {carry, sum}.
    function automatic logic [1:0] full_adder(input logic x, input logic y, input logic ci);
        logic s;
        logic c;
        s = x ^ y ^ ci;
        c = (x & y) | (x & ci) | (y & ci);
        return {c, s};
    endfunction

    state_t           state_r;
    state_t           state_s;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] res_r;

    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;

    logic             fa_sum_s;
    logic             fa_carry_s;
    logic             last_bit_s;
    logic [WIDTH-1:0] res_shift_s;
    logic             busy_s;
    logic             done_s;

    // Shared adder datapath and the result shifted in from the MSB side.
    // The shift/or form avoids an empty slice when WIDTH is 1.
    always_comb begin
        {fa_carry_s, fa_sum_s} = full_adder(a_r[0], b_r[0], carry_r);
        res_shift_s = (res_r >> 1) | (WIDTH'(fa_sum_s) << (WIDTH - 1));
        last_bit_s  = (cnt_r == CW'(WIDTH - 1));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_bit_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode from the next state, so the registered flags line up
    // with the state they describe.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_s)
            ST_IDLE: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
            ST_RUN: begin
                busy_s = 1'b1;
                done_s = 1'b0;
            end
            ST_DONE: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Handshake output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    // Operand shift registers, carry, bit counter and partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            res_r   <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        cnt_r   <= {CW{1'b0}};
                        res_r   <= {WIDTH{1'b0}};
                    end else begin
                        a_r     <= a_r;
                        b_r     <= b_r;
                        carry_r <= carry_r;
                        cnt_r   <= cnt_r;
                        res_r   <= res_r;
                    end
                end
                ST_RUN: begin
                    a_r     <= a_r >> 1;
                    b_r     <= b_r >> 1;
                    carry_r <= fa_carry_s;
                    cnt_r   <= cnt_r + CW'(1);
                    res_r   <= res_shift_s;
                end
                default: begin
                    a_r     <= a_r;
                    b_r     <= b_r;
                    carry_r <= carry_r;
                    cnt_r   <= cnt_r;
                    res_r   <= res_r;
                end
            endcase
        end
    end

    // Visible result: updated only on the final RUN edge, so partial sums
    // never appear on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
        end else begin
            if ((state_r == ST_RUN) && last_bit_s) begin
                sum_r  <= res_shift_s;
                cout_r <= fa_carry_s;
            end else begin
                sum_r  <= sum_r;
                cout_r <= cout_r;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule
